spi_dac_rx: RTL and testbench
=============================

// Module: spi_dac_rx
// PURPOSE
//   SPI responder for the LTC2624-style 32-bit DAC frame driven by the DAC/SPI master (SPI_SCK/SPI_MOSI/DAC_CS/DAC_CLR).
//   Oversamples the SPI pins with CLK, decodes cmd/addr/data, echoes the previous frame on SPI_MISO as the DAC does.
//   Serves as loopback/bench model for the master and as an on-chip frame monitor in top.
// PARAMETERS
//   FRAME_BITS   32  bits per valid frame; any other count at CS rise is an error
//   SYNC_STAGES  2   flip-flop stages on each async input (SCK, MOSI, CS, CLR); >=2
// PORTS
//   CLK        in   1   system clock; all logic on rising edge
//   RST        in   1   synchronous reset, active-high
//   SPI_SCK    in   1   SPI clock from master (async to CLK)
//   SPI_MOSI   in   1   serial data from master, MSB first
//   DAC_CS     in   1   chip select, active-low, frames a transfer
//   DAC_CLR    in   1   async clear request, active-low
//   SPI_MISO   out  1   echo of previous accepted frame, MSB first
//   cmd        out  4   frame bits [23:20] of last accepted frame
//   addr       out  4   frame bits [19:16]
//   data       out  12  frame bits [15:4]
//   valid      out  1   1-CLK pulse: cmd/addr/data updated
//   frame_err  out  1   1-CLK pulse: CS rose with bit count != FRAME_BITS
// BEHAVIOUR
//   - Reset: SPI_MISO=0, cmd=0, addr=0, data=0, valid=0, frame_err=0, sr=0, echo=0, bit_cnt=0, state=IDLE, armed=0.
//   - Inputs pass SYNC_STAGES syncs; edges = synced value vs. one extra registered copy.
//     Event latency: action registered SYNC_STAGES+1 CLK after pin change.
//   - Timing requirement: SCK high and low each >= SYNC_STAGES+2 CLK; slower SCK is always legal.
//   - FSM: IDLE -> SHIFT on CS fall (armed=1 only); SHIFT -> CHECK on CS rise; CHECK -> IDLE after 1 cycle.
//     armed sets whenever synced CS is high in IDLE; a CS low at reset exit is ignored until CS rises.
//   - CS fall: bit_cnt<=0, SPI_MISO<=echo[31], echo shift pointer reset.
//   - SHIFT, SCK rise: sr<={sr[30:0],MOSI}; bit_cnt+1, saturates at 63 (6 bits).
//   - SHIFT, SCK fall: SPI_MISO<=next echo bit (MSB first); after 32 bits SPI_MISO=0.
//   - CHECK: bit_cnt==FRAME_BITS -> cmd/addr/data<=sr fields, echo<=sr, valid=1.
//     Otherwise frame_err=1; cmd/addr/data/echo unchanged.
//   - Bits [31:24] and [3:0] are don't-care; never decoded.
//   - Simultaneous CS rise and SCK edge in one cycle: CS wins, SCK edge dropped.
//   - Simultaneous CS fall and SCK edge: CS fall only; the first SCK rise is counted from the following edge.
//   - CLR (synced low, level): echo=0, sr=0, bit_cnt=0, state=IDLE, armed=0; cmd/addr/data kept; no valid/err.
//     Mid-frame CLR aborts the frame silently.
//   - RST mid-frame: identical to power-up reset; the frame in flight is discarded.
//   - valid and frame_err are mutually exclusive; neither is asserted for longer than 1 CLK.
// CONFIGURATION
//   SPI_DAC_RX_CHREG_EN defined: adds outputs ch_a, ch_b, ch_c, ch_d [11:0], reset 0.
//     On valid with cmd=4'b0011: addr 0..3 -> that channel<=data.
//     On valid with cmd=4'b0011, addr=4'b1111: all four channels<=data.
//     Other cmd/addr values: channels unchanged.
//     CLR low: all channels<=0.
//   Not defined: channel ports and registers absent; decoded outputs only.
// TESTING
//   - Reset: RST=1 one CLK, then RST=0 -> all outputs 0; no valid/frame_err for 50 CLK with CS high.
//   - Frame 0x00_3_2_ABC_0 at SPI_CDIV=10 -> one valid pulse; cmd=3, addr=2, data=12'hABC.
//   - Frame 0x0F1234F5 then 0x00000000 -> second frame shifts 0x0F1234F5 out on SPI_MISO, MSB first.
//     (CHREG_EN also: ch_c=12'hABC after the first scenario.)
//   - Short frame of 31 bits -> frame_err pulse, no valid, cmd/addr/data held.
//     Frame of 40 bits -> frame_err pulse likewise.
//   - DAC_CLR low 8 CLK at bit 16 of a frame -> no pulses, next MISO echo all 0.
//     Next full frame is accepted normally.
//   - RST at bit 10 of a frame, CS still low -> no pulses for the rest of that frame.
//     Next CS-framed 32-bit transfer is accepted (valid=1).
//     CHREG_EN: cmd=3, addr=F, data=12'h555 -> ch_a..ch_d all 12'h555.

Source files
------------

// File: rtl/spi_dac_rx.sv
// spi_dac_rx: SPI responder for a 32-bit LTC2624-style DAC frame.
// Oversamples SCK/MOSI/CS/CLR with CLK, decodes cmd/addr/data from an
// accepted frame and echoes the previously accepted frame on SPI_MISO.
// Optional feature macro: SPI_DAC_RX_CHREG_EN adds per-channel data
// registers ch_a..ch_d written by cmd 4'b0011 frames.
module spi_dac_rx #(
    parameter int FRAME_BITS  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SPI_SCK,
    input  logic        SPI_MOSI,
    input  logic        DAC_CS,
    input  logic        DAC_CLR,
    output logic        SPI_MISO,
    output logic [3:0]  cmd,
    output logic [3:0]  addr,
    output logic [11:0] data,
    output logic        valid,
    output logic        frame_err
`ifdef SPI_DAC_RX_CHREG_EN
    ,
    output logic [11:0] ch_a,
    output logic [11:0] ch_b,
    output logic [11:0] ch_c,
    output logic [11:0] ch_d
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_clr_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;

    logic w_sck_s, w_mosi_s, w_cs_s, w_clr_s;
    logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;

    state_t      r_state;
    logic        r_armed;
    logic [31:0] r_sr;
    logic [31:0] r_echo;
    logic [31:0] r_tx;
    logic [5:0]  r_bit_cnt;

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_clr_s    = r_clr_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s & r_sck_d;
    assign w_cs_rise  = w_cs_s & ~r_cs_d;
    assign w_cs_fall  = ~w_cs_s & r_cs_d;

    // Synchronise the asynchronous pins and keep one delayed copy for edges.
    // Synchronisers reset low so a CS held low across reset never looks armed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '0;
            r_clr_sync  <= '0;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SPI_SCK};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], DAC_CS};
            r_clr_sync  <= {r_clr_sync[SYNC_STAGES-2:0], DAC_CLR};
            r_sck_d     <= w_sck_s;
            r_cs_d      <= w_cs_s;
        end
    end

    // Frame FSM: shift in on SCK rise, echo out on SCK fall, decode at CS rise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_armed   <= 1'b0;
            r_sr      <= '0;
            r_echo    <= '0;
            r_tx      <= '0;
            r_bit_cnt <= '0;
            SPI_MISO  <= 1'b0;
            cmd       <= '0;
            addr      <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef SPI_DAC_RX_CHREG_EN
            ch_a      <= '0;
            ch_b      <= '0;
            ch_c      <= '0;
            ch_d      <= '0;
`endif
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (!w_clr_s) begin
                // Clear is a level: hold everything idle and disarmed while low.
                r_state   <= S_IDLE;
                r_armed   <= 1'b0;
                r_sr      <= '0;
                r_echo    <= '0;
                r_tx      <= '0;
                r_bit_cnt <= '0;
`ifdef SPI_DAC_RX_CHREG_EN
                ch_a      <= '0;
                ch_b      <= '0;
                ch_c      <= '0;
                ch_d      <= '0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cs_s) begin
                            r_armed <= 1'b1;
                        end
                        if (w_cs_fall && r_armed) begin
                            r_state   <= S_SHIFT;
                            r_bit_cnt <= '0;
                            SPI_MISO  <= r_echo[31];
                            r_tx      <= {r_echo[30:0], 1'b0};
                        end
                    end
                    S_SHIFT: begin
                        // CS rise takes priority; a coincident SCK edge is dropped.
                        if (w_cs_rise) begin
                            r_state <= S_CHECK;
                        end else if (w_sck_rise) begin
                            r_sr <= {r_sr[30:0], w_mosi_s};
                            if (r_bit_cnt != 6'd63) begin
                                r_bit_cnt <= r_bit_cnt + 6'd1;
                            end
                        end else if (w_sck_fall) begin
                            SPI_MISO <= r_tx[31];
                            r_tx     <= {r_tx[30:0], 1'b0};
                        end
                    end
                    S_CHECK: begin
                        r_state <= S_IDLE;
                        if (r_bit_cnt == 6'(FRAME_BITS)) begin
                            cmd    <= r_sr[23:20];
                            addr   <= r_sr[19:16];
                            data   <= r_sr[15:4];
                            r_echo <= r_sr;
                            valid  <= 1'b1;
`ifdef SPI_DAC_RX_CHREG_EN
                            if (r_sr[23:20] == 4'b0011) begin
                                case (r_sr[19:16])
                                    4'h0: ch_a <= r_sr[15:4];
                                    4'h1: ch_b <= r_sr[15:4];
                                    4'h2: ch_c <= r_sr[15:4];
                                    4'h3: ch_d <= r_sr[15:4];
                                    4'hF: begin
                                        ch_a <= r_sr[15:4];
                                        ch_b <= r_sr[15:4];
                                        ch_c <= r_sr[15:4];
                                        ch_d <= r_sr[15:4];
                                    end
                                    default: ;
                                endcase
                            end
`endif
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_dac_rx.sv
// Testbench for spi_dac_rx: directed SPI frames, scoreboard of expected
// valid/frame_err pulses checked by an independent monitor.
module tb_spi_dac_rx;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        SPI_SCK = 1'b0;
    logic        SPI_MOSI = 1'b0;
    logic        DAC_CS = 1'b1;
    logic        DAC_CLR = 1'b1;
    logic        SPI_MISO;
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [11:0] data;
    logic        valid;
    logic        frame_err;
`ifdef SPI_DAC_RX_CHREG_EN
    logic [11:0] ch_a, ch_b, ch_c, ch_d;
`endif

    spi_dac_rx #(.FRAME_BITS(32), .SYNC_STAGES(2)) dut (
        .CLK(CLK), .RST(RST), .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI),
        .DAC_CS(DAC_CS), .DAC_CLR(DAC_CLR), .SPI_MISO(SPI_MISO),
        .cmd(cmd), .addr(addr), .data(data), .valid(valid), .frame_err(frame_err)
`ifdef SPI_DAC_RX_CHREG_EN
        , .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .ch_d(ch_d)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        is_err;
        logic [3:0]  c;
        logic [3:0]  a;
        logic [11:0] d;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_echo = '0;
    logic [3:0]  cur_cmd = '0;
    logic [3:0]  cur_addr = '0;
    logic [11:0] cur_data = '0;
    logic        prev_pulse = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Monitor: every output pulse is matched against the scoreboard.
    always @(negedge CLK) begin
        if (valid || frame_err) begin
            check("pulse_exclusive", {63'b0, valid & frame_err}, 64'd0);
            check("pulse_width", {63'b0, prev_pulse}, 64'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pulse: valid=%0b frame_err=%0b expected no pulse",
                         valid, frame_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind", {63'b0, frame_err}, {63'b0, e.is_err});
                check("cmd", {60'b0, cmd}, {60'b0, e.c});
                check("addr", {60'b0, addr}, {60'b0, e.a});
                check("data", {52'b0, data}, {52'b0, e.d});
            end
        end
        prev_pulse <= valid | frame_err;
    end

    // Drive one CS-framed transfer of n bits (MSB first) at 10 CLK per SCK half period.
    task automatic send_frame(input logic [63:0] val, input int n, input int clr_at,
                              input int rst_at, input logic chk_miso);
        logic [63:0] rx;
        logic [63:0] exp_seq;
        logic [63:0] mask;
        rx      = '0;
        exp_seq = {exp_echo, 32'b0};
        mask    = ~(64'hFFFF_FFFF_FFFF_FFFF >> n);
        DAC_CS  = 1'b0;
        tick(10);
        for (int i = 0; i < n; i++) begin
            if (i == clr_at) begin
                DAC_CLR = 1'b0;
                tick(8);
                DAC_CLR = 1'b1;
            end
            if (i == rst_at) begin
                RST = 1'b1;
                tick(1);
                RST = 1'b0;
            end
            SPI_MOSI = val[n-1-i];
            tick(10);
            rx[63-i] = SPI_MISO;
            SPI_SCK = 1'b1;
            tick(10);
            SPI_SCK = 1'b0;
        end
        tick(10);
        DAC_CS = 1'b1;
        tick(20);
        if (chk_miso) check("miso_echo", rx & mask, exp_seq & mask);
    endtask

    task automatic frame_ok(input logic [31:0] val);
        exp_q.push_back({1'b0, val[23:20], val[19:16], val[15:4]});
        send_frame({32'b0, val}, 32, -1, -1, 1'b1);
        exp_echo = val;
        cur_cmd  = val[23:20];
        cur_addr = val[19:16];
        cur_data = val[15:4];
    endtask

    task automatic frame_bad(input logic [63:0] val, input int n);
        exp_q.push_back({1'b1, cur_cmd, cur_addr, cur_data});
        send_frame(val, n, -1, -1, 1'b1);
    endtask

    initial begin
        RST = 1'b1;
        tick(1);
        RST = 1'b0;
        tick(2);
        check("rst_miso", {63'b0, SPI_MISO}, 64'd0);
        check("rst_cmd", {60'b0, cmd}, 64'd0);
        check("rst_addr", {60'b0, addr}, 64'd0);
        check("rst_data", {52'b0, data}, 64'd0);
        check("rst_valid", {63'b0, valid}, 64'd0);
        check("rst_err", {63'b0, frame_err}, 64'd0);
        tick(50);

        frame_ok(32'h0032_ABC0);
`ifdef SPI_DAC_RX_CHREG_EN
        check("ch_c_abc", {52'b0, ch_c}, {52'b0, 12'hABC});
        check("ch_a_zero", {52'b0, ch_a}, 64'd0);
`endif
        frame_ok(32'h0F12_34F5);
        frame_bad({32'b0, 32'h7F12_34F5} >> 1, 31);
        frame_bad(64'h0000_0012_3456_789A, 40);
        frame_ok(32'h0000_0000);

        frame_ok(32'h0031_1230);
        send_frame({32'b0, 32'h0032_2220}, 32, 16, -1, 1'b0);
        exp_echo = '0;
        check("clr_cmd_held", {60'b0, cmd}, 64'd3);
        check("clr_addr_held", {60'b0, addr}, 64'd1);
        check("clr_data_held", {52'b0, data}, {52'b0, 12'h123});
`ifdef SPI_DAC_RX_CHREG_EN
        check("clr_ch_b", {52'b0, ch_b}, 64'd0);
`endif
        frame_ok(32'h0030_4560);
`ifdef SPI_DAC_RX_CHREG_EN
        check("ch_a_456", {52'b0, ch_a}, {52'b0, 12'h456});
`endif

        send_frame({32'b0, 32'h0033_7770}, 32, -1, 10, 1'b0);
        exp_echo = '0;
        cur_cmd  = '0;
        cur_addr = '0;
        cur_data = '0;
        check("rstmid_cmd", {60'b0, cmd}, 64'd0);
        check("rstmid_data", {52'b0, data}, 64'd0);
        frame_ok(32'h003F_5550);
`ifdef SPI_DAC_RX_CHREG_EN
        check("ch_a_555", {52'b0, ch_a}, {52'b0, 12'h555});
        check("ch_b_555", {52'b0, ch_b}, {52'b0, 12'h555});
        check("ch_c_555", {52'b0, ch_c}, {52'b0, 12'h555});
        check("ch_d_555", {52'b0, ch_d}, {52'b0, 12'h555});
`endif
        tick(20);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
